pipe_hazard_ctrl: RTL and testbench

Pipeline control unit that generates the per-stage `write` (hold) and `flush` (bubble) strobes consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers, plus the PC write enable. It detects load-use hazards, squashes wrong-path instructions on a taken branch resolved in MEM, and runs a counter-driven FSM that freezes the pipeline for a fixed data-memory latency. It sits beside the datapath in the top-level CPU and is the single producer of every pipe-register control strobe.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/load_use_detect.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and the register file:
// the FSM state encoding, the default memory latency and the register-index width.
package pipe_ctrl_pkg;

  localparam int REG_AW      = 5;
  localparam int MEM_LAT_DEF = 2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the datapath (master) and the hazard controller (slave):
// hazard-relevant fields of the in-flight instructions and the pipe-register strobes.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = pipe_ctrl_pkg::REG_AW
);

  logic [REG_AW-1:0] ifid_rs_i;
  logic [REG_AW-1:0] ifid_rt_i;
  logic              ifid_uses_rt_i;
  logic              idex_memread_i;
  logic [REG_AW-1:0] idex_rt_i;
  logic              exmem_mem_i;
  logic              branch_taken_i;

  logic pc_write_o;
  logic ifid_write_o;
  logic idex_write_o;
  logic exmem_write_o;
  logic memwb_write_o;
  logic ifid_flush_o;
  logic idex_flush_o;
  logic exmem_flush_o;
  logic memwb_flush_o;

  modport master (
    output ifid_rs_i, ifid_rt_i, ifid_uses_rt_i, idex_memread_i, idex_rt_i,
           exmem_mem_i, branch_taken_i,
    input  pc_write_o, ifid_write_o, idex_write_o, exmem_write_o, memwb_write_o,
           ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o
  );

  modport slave (
    input  ifid_rs_i, ifid_rt_i, ifid_uses_rt_i, idex_memread_i, idex_rt_i,
           exmem_mem_i, branch_taken_i,
    output pc_write_o, ifid_write_o, idex_write_o, exmem_write_o, memwb_write_o,
           ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Register 0 never creates a hazard.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = pipe_ctrl_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] ifid_rs_i,
  input  logic [REG_AW-1:0] ifid_rt_i,
  input  logic              ifid_uses_rt_i,
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rt_i,
  output logic              hazard_o
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = (idex_rt_i == ifid_rs_i);
    rt_match = ifid_uses_rt_i && (idex_rt_i == ifid_rt_i);
    hazard_o = idex_memread_i && (idex_rt_i != '0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit: per-stage write/flush strobes, PC enable and memory-wait FSM.
// Define PIPE_HAZ_STATS_EN to add the saturating stall_cnt_o statistics counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = pipe_ctrl_pkg::REG_AW,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic               clk_i,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  bus
`ifdef PIPE_HAZ_STATS_EN
  ,
  output logic [31:0]        stall_cnt_o
`endif
);

  localparam int                CNT_W    = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = (MEM_LAT >= 2) ? CNT_W'(MEM_LAT - 2) : '0;
  localparam bit                MEM_EN   = (MEM_LAT > 0);
  localparam ctrl_state_e       MEM_NEXT = (MEM_LAT >= 2) ? WAIT : DRAIN;

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_stall;
  logic             load_use;

  logic pc_write;
  logic ifid_write, idex_write, exmem_write, memwb_write;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_load_use_detect (
    .ifid_rs_i      (bus.ifid_rs_i),
    .ifid_rt_i      (bus.ifid_rt_i),
    .ifid_uses_rt_i (bus.ifid_uses_rt_i),
    .idex_memread_i (bus.idex_memread_i),
    .idex_rt_i      (bus.idex_rt_i),
    .hazard_o       (load_use)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The triggering RUN cycle is the first stall cycle, so WAIT covers the remaining MEM_LAT-1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    unique case (state_q)
      RUN: begin
        if (MEM_EN && bus.exmem_mem_i) begin
          mem_stall = 1'b1;
          state_d   = MEM_NEXT;
          cnt_d     = CNT_INIT;
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (cnt_q == '0) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DRAIN: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (mem_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_flush = 1'b1;
    end else if (bus.branch_taken_i) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_flush  = 1'b1;
    end
  end

  assign bus.pc_write_o    = pc_write;
  assign bus.ifid_write_o  = ifid_write;
  assign bus.idex_write_o  = idex_write;
  assign bus.exmem_write_o = exmem_write;
  assign bus.memwb_write_o = memwb_write;
  assign bus.ifid_flush_o  = ifid_flush;
  assign bus.idex_flush_o  = idex_flush;
  assign bus.exmem_flush_o = exmem_flush;
  assign bus.memwb_flush_o = memwb_flush;

`ifdef PIPE_HAZ_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Every cycle without a PC update counts; branch flushes keep the PC moving and are excluded.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: four instances (MEM_LAT 0,1,3,4) share one
// stimulus stream; a cycle-level reference model predicts every strobe and the stall count.
module tb_pipe_hazard_ctrl;

  localparam int N  = 4;
  localparam int AW = pipe_ctrl_pkg::REG_AW;

  // Strobe vector order: {pc, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, exmem_f, memwb_f}
  localparam logic [8:0] OUT_NORMAL = 9'b11111_0000;
  localparam logic [8:0] OUT_BRANCH = 9'b11111_1110;
  localparam logic [8:0] OUT_LDUSE  = 9'b00111_0100;
  localparam logic [8:0] OUT_STALL  = 9'b00001_0001;

  typedef struct packed {
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          usesRt;
    logic          memread;
    logic [AW-1:0] idexRt;
    logic          mem;
    logic          br;
  } stim_t;

  typedef struct {
    logic [N-1:0][8:0]  strb;
    logic [N-1:0][31:0] cnt;
    int                 cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] rs = '0, rt = '0, idexRt = '0;
  logic          usesRt = 1'b0, memread = 1'b0, mem = 1'b0, br = 1'b0;

  logic [8:0] dutStrb [N];
`ifdef PIPE_HAZ_STATS_EN
  logic [31:0] dutCnt [N];
`endif

  for (genvar i = 0; i < N; i++) begin : g_dut
    localparam int LAT = (i == 0) ? 0 : (i == 1) ? 1 : (i == 2) ? 3 : 4;

    pipe_hazard_ctrl_if #(.REG_AW(AW)) bus ();

    assign bus.ifid_rs_i      = rs;
    assign bus.ifid_rt_i      = rt;
    assign bus.ifid_uses_rt_i = usesRt;
    assign bus.idex_memread_i = memread;
    assign bus.idex_rt_i      = idexRt;
    assign bus.exmem_mem_i    = mem;
    assign bus.branch_taken_i = br;

    assign dutStrb[i] = {bus.pc_write_o, bus.ifid_write_o, bus.idex_write_o,
                         bus.exmem_write_o, bus.memwb_write_o, bus.ifid_flush_o,
                         bus.idex_flush_o, bus.exmem_flush_o, bus.memwb_flush_o};

    pipe_hazard_ctrl #(
      .REG_AW  (AW),
      .MEM_LAT (LAT)
    ) dut (
      .clk_i (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef PIPE_HAZ_STATS_EN
      ,
      .stall_cnt_o (dutCnt[i])
`endif
    );
  end

  int          lats [N] = '{0, 1, 3, 4};
  int          stallLeft [N];
  bit          inDrain [N];
  int unsigned stat [N];
  exp_t        sbq [$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic stim_t mk(int r1, int r2, bit u, bit mr, int irt, bit m, bit b);
    stim_t s;
    s.rs      = AW'(r1);
    s.rt      = AW'(r2);
    s.usesRt  = u;
    s.memread = mr;
    s.idexRt  = AW'(irt);
    s.mem     = m;
    s.br      = b;
    return s;
  endfunction

  function automatic bit loadUse(stim_t s);
    return s.memread && (s.idexRt != 0) &&
           ((s.idexRt == s.rs) || (s.usesRt && (s.idexRt == s.rt)));
  endfunction

  // left = stall cycles still owed after the current one; drain = next free cycle is the release cycle
  function automatic void modelStep(input int lat, input stim_t s, inout int left,
                                    inout bit drain, output logic [8:0] o);
    bit memStall;
    memStall = 1'b0;
    if (left > 0) begin
      memStall = 1'b1;
      left--;
      if (left == 0) drain = 1'b1;
    end else if (drain) begin
      drain = 1'b0;
    end else if (lat > 0 && s.mem) begin
      memStall = 1'b1;
      left = lat - 1;
      if (left == 0) drain = 1'b1;
    end
    if (memStall)       o = OUT_STALL;
    else if (s.br)      o = OUT_BRANCH;
    else if (loadUse(s)) o = OUT_LDUSE;
    else                o = OUT_NORMAL;
  endfunction

  task automatic applyStimulus(input stim_t s, input logic rstVal);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n   = rstVal;
    rs      = s.rs;
    rt      = s.rt;
    usesRt  = s.usesRt;
    memread = s.memread;
    idexRt  = s.idexRt;
    mem     = s.mem;
    br      = s.br;
    e.cyc   = cyc;
    for (int k = 0; k < N; k++) begin
      int         l;
      bit         d;
      logic [8:0] o;
      if (!rstVal) begin
        stallLeft[k] = 0;
        inDrain[k]   = 1'b0;
        stat[k]      = 0;
      end
      l = stallLeft[k];
      d = inDrain[k];
      modelStep(lats[k], s, l, d, o);
      e.strb[k] = o;
      e.cnt[k]  = stat[k];
      if (rstVal) begin
        stallLeft[k] = l;
        inDrain[k]   = d;
        if (!o[8] && stat[k] != 32'hFFFF_FFFF) stat[k]++;
      end
    end
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int lat, input int c,
                             input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s lat=%0d cyc=%0d got=0x%0h expected=0x%0h", name, lat, c, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        for (int k = 0; k < N; k++) begin
          checkOutput("strobes", lats[k], e.cyc, {23'd0, dutStrb[k]}, {23'd0, e.strb[k]});
`ifdef PIPE_HAZ_STATS_EN
          checkOutput("stall_cnt", lats[k], e.cyc, dutCnt[k], e.cnt[k]);
`endif
        end
      end
    end
  end

  initial begin : driver
    stim_t idle;
    stim_t s;
    logic  r;
    idle = mk(0, 0, 0, 0, 0, 0, 0);

    repeat (2) applyStimulus(idle, 1'b0);
    repeat (2) applyStimulus(idle, 1'b1);

    applyStimulus(mk(5, 0, 0, 1, 5, 0, 0), 1'b1);
    applyStimulus(mk(5, 0, 0, 0, 0, 0, 0), 1'b1);
    applyStimulus(mk(5, 0, 0, 1, 0, 0, 0), 1'b1);
    applyStimulus(mk(0, 0, 0, 1, 0, 0, 0), 1'b1);
    applyStimulus(mk(2, 7, 1, 1, 7, 0, 0), 1'b1);
    applyStimulus(mk(2, 7, 0, 1, 7, 0, 0), 1'b1);
    applyStimulus(mk(5, 0, 0, 1, 5, 0, 1), 1'b1);
    applyStimulus(idle, 1'b1);

    repeat (4) applyStimulus(mk(0, 0, 0, 0, 0, 1, 0), 1'b1);
    repeat (5) applyStimulus(idle, 1'b1);

    applyStimulus(mk(0, 0, 0, 0, 0, 1, 0), 1'b1);
    applyStimulus(idle, 1'b0);
    repeat (3) applyStimulus(idle, 1'b1);

    for (int n = 0; n < 600; n++) begin
      s.rs      = AW'($urandom_range(0, 3));
      s.rt      = AW'($urandom_range(0, 3));
      s.usesRt  = 1'($urandom_range(0, 1));
      s.memread = ($urandom_range(0, 2) == 0);
      s.idexRt  = AW'($urandom_range(0, 3));
      s.mem     = ($urandom_range(0, 4) == 0);
      s.br      = ($urandom_range(0, 5) == 0);
      r         = ($urandom_range(0, 149) != 0);
      applyStimulus(s, r);
    end
    applyStimulus(idle, 1'b1);

    @(negedge clk);
    #1;
    for (int t = 0; t < 10 && sbq.size() > 0; t++) begin
      @(negedge clk);
      #1;
    end
    if (sbq.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain pending=%0d expected=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
